xosera_host_bus: RTL and testbench

XOSERA_HOST_BUS -- requirements
Module: xosera_host_bus

---
 rtl/xosera_host_bus.sv | 103 ++++++++++
 tb/tb_xosera_host_bus.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/xosera_host_bus.sv
// xosera_host_bus: sequences 16-bit register commands as two 8-bit strobed bus cycles.
// Also provides a synchronized, sticky interrupt flag.
module xosera_host_bus #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rd_nwr_i,
  input  logic [3:0]  cmd_reg_num_i,
  input  logic [15:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_intr_i,
  input  logic        intr_clear_i,
  output logic        intr_pending_o
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
  localparam logic [3:0] S_L = 4'(SETUP_CYC - 1);
  localparam logic [3:0] P_L = 4'(STROBE_CYC - 1);
  localparam logic [3:0] H_L = 4'(HOLD_CYC - 1);
  state_t state, nxt;
  logic idx, nidx, last, accept, load, src_rd, sync_d;
  logic [3:0] cnt, ncnt;
  logic [15:0] wdata, rd_buf, src_w;
  logic [1:0] sync;
  assign last = cnt == 4'd0;
  assign cmd_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign load = nxt == SETUP && state != SETUP;
  // on the accept cycle the command is still only on the inputs
  assign src_rd = cmd_ready_o ? cmd_rd_nwr_i : bus_rd_nwr_o;
  assign src_w = cmd_ready_o ? cmd_wdata_i : wdata;
  always_comb begin
    nxt = state;
    nidx = idx;
    ncnt = last ? cnt : cnt - 4'd1;
    case (state)
      IDLE:   if (cmd_valid_i) begin nxt = SETUP; nidx = 1'b0; ncnt = S_L; end
      SETUP:  if (last) begin nxt = STROBE; ncnt = P_L; end
      STROBE: if (last) begin nxt = HOLD; ncnt = H_L; end
      HOLD:   if (last) begin nxt = idx ? DONE : SETUP; nidx = 1'b1; ncnt = S_L; end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      idx <= 1'b0;
      cnt <= 4'd0;
      wdata <= 16'd0;
      rd_buf <= 16'd0;
      bus_cs_n_o <= 1'b1;
      bus_rd_nwr_o <= 1'b1;
      bus_reg_num_o <= 4'd0;
      bus_bytesel_o <= 1'b0;
      bus_data_o <= 8'd0;
      bus_data_oe_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 16'd0;
      sync <= 2'b00;
      sync_d <= 1'b0;
      intr_pending_o <= 1'b0;
    end else begin
      state <= nxt;
      idx <= nidx;
      cnt <= ncnt;
      bus_cs_n_o <= nxt != STROBE;
      rsp_valid_o <= nxt == DONE;
      if (accept) begin
        wdata <= cmd_wdata_i;
        bus_rd_nwr_o <= cmd_rd_nwr_i;
        bus_reg_num_o <= cmd_reg_num_i;
      end
      if (load) begin
        bus_bytesel_o <= nidx;
        bus_data_o <= src_rd ? 8'h00 : (nidx ? src_w[7:0] : src_w[15:8]);
        bus_data_oe_o <= !src_rd;
      end
      if (nxt == DONE) bus_data_oe_o <= 1'b0;
      if (state == STROBE && last && bus_rd_nwr_o) begin
        if (idx) rd_buf[7:0] <= bus_data_i;
        else rd_buf[15:8] <= bus_data_i;
      end
      if (nxt == DONE && bus_rd_nwr_o) rsp_rdata_o <= rd_buf;
      sync <= {sync[0], bus_intr_i};
      sync_d <= sync[1];
      intr_pending_o <= (sync[1] && !sync_d) || (intr_pending_o && !intr_clear_i);
    end
  end
endmodule

// File: tb/tb_xosera_host_bus.sv
// tb_xosera_host_bus: scoreboard bench for xosera_host_bus with a simple Xosera bus responder.
module tb_xosera_host_bus;
  localparam int LAT = 2 * (1 + 4 + 2) + 1;
  localparam int STB = 4;
  typedef struct packed {logic rd; logic [3:0] r; logic bi; logic [7:0] d;} byte_t;
  logic clk = 1'b0, reset_i = 1'b1;
  logic cmd_valid_i = 1'b0, cmd_ready_o, cmd_rd_nwr_i = 1'b0;
  logic [3:0] cmd_reg_num_i = 4'd0;
  logic [15:0] cmd_wdata_i = 16'd0, rsp_rdata_o;
  logic rsp_valid_o, busy_o, bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_data_oe_o;
  logic [3:0] bus_reg_num_o;
  logic [7:0] bus_data_o, bus_data_i, rd_hi = 8'h00, rd_lo = 8'h00;
  logic bus_intr_i = 1'b0, intr_clear_i = 1'b0, intr_pending_o;
  byte_t bq[$];
  logic [15:0] rq[$];
  logic [15:0] last_rd = 16'd0;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0, rsp_cyc = 0, run = 0;
  logic prev_cs = 1'b1;
  xosera_host_bus dut (
    .clk(clk), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_rd_nwr_i(cmd_rd_nwr_i),
    .cmd_reg_num_i(cmd_reg_num_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o),
    .bus_cs_n_o(bus_cs_n_o), .bus_rd_nwr_o(bus_rd_nwr_o), .bus_reg_num_o(bus_reg_num_o),
    .bus_bytesel_o(bus_bytesel_o), .bus_data_o(bus_data_o), .bus_data_oe_o(bus_data_oe_o),
    .bus_data_i(bus_data_i), .bus_intr_i(bus_intr_i), .intr_clear_i(intr_clear_i),
    .intr_pending_o(intr_pending_o)
  );
  assign bus_data_i = bus_bytesel_o ? rd_lo : rd_hi;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (reset_i) begin
      bq.delete();
      rq.delete();
      last_rd = 16'd0;
      run = 0;
      prev_cs = 1'b1;
    end else begin
      if (cmd_valid_i && cmd_ready_o) begin
        acc_cyc = cyc;
        bq.push_back('{cmd_rd_nwr_i, cmd_reg_num_i, 1'b0, cmd_wdata_i[15:8]});
        bq.push_back('{cmd_rd_nwr_i, cmd_reg_num_i, 1'b1, cmd_wdata_i[7:0]});
        if (cmd_rd_nwr_i) last_rd = {rd_hi, rd_lo};
        rq.push_back(last_rd);
      end
      if (!bus_cs_n_o) run++;
      if (bus_cs_n_o && !prev_cs) begin
        if (bq.size() == 0) check("strobe_extra", 1, 0);
        else begin
          byte_t e;
          e = bq.pop_front();
          check("strobe_len", run, STB);
          check("reg_num", bus_reg_num_o, e.r);
          check("rd_nwr", bus_rd_nwr_o, e.rd);
          check("oe", bus_data_oe_o, !e.rd);
          if (e.rd) check("bytesel", bus_bytesel_o, e.bi);
          else check("wbyte", {bus_bytesel_o, bus_data_o}, {e.bi, e.d});
        end
        run = 0;
      end
      if (rsp_valid_o) begin
        if (rq.size() == 0) check("rsp_extra", 1, 0);
        else begin
          check("rdata", rsp_rdata_o, rq.pop_front());
          check("latency", cyc - acc_cyc, LAT);
          check("oe_done", bus_data_oe_o, 0);
        end
        rsp_cyc = cyc;
      end
      prev_cs = bus_cs_n_o;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic rd, input logic [3:0] r, input logic [15:0] w);
    int n;
    cmd_valid_i = 1'b1;
    cmd_rd_nwr_i = rd;
    cmd_reg_num_i = r;
    cmd_wdata_i = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready_o && n < 100);
    if (!cmd_ready_o) check("accept_timeout", 1, 0);
    tick();
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 100);
    if (busy_o) check("idle_timeout", 1, 0);
    tick();
    tick();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick();
    check("rst_cs_n", bus_cs_n_o, 1);
    check("rst_rd_nwr", bus_rd_nwr_o, 1);
    check("rst_reg", bus_reg_num_o, 0);
    check("rst_bsel", bus_bytesel_o, 0);
    check("rst_data", bus_data_o, 0);
    check("rst_oe", bus_data_oe_o, 0);
    check("rst_rsp", {rsp_valid_o, rsp_rdata_o}, 0);
    check("rst_intr", intr_pending_o, 0);
    check("rst_ready_busy", {cmd_ready_o, busy_o}, 2'b10);
    reset_i = 1'b0;
    tick();
    send(1'b0, 4'd3, 16'hA55A);
    cmd_valid_i = 1'b0;
    wait_idle();
    rd_hi = 8'h12;
    rd_lo = 8'h34;
    send(1'b1, 4'd2, 16'hFFFF);
    cmd_valid_i = 1'b0;
    wait_idle();
    send(1'b0, 4'd5, 16'h0F0F);
    cmd_valid_i = 1'b0;
    wait_idle();
    rd_hi = 8'hAB;
    rd_lo = 8'hCD;
    send(1'b1, 4'd7, 16'h0000);
    send(1'b0, 4'd9, 16'hBEEF);
    check("b2b_gap", acc_cyc - rsp_cyc, 1);
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 30 && busy_o; i++) begin
      cmd_rd_nwr_i = 1'($urandom);
      cmd_reg_num_i = 4'($urandom);
      cmd_wdata_i = 16'($urandom);
      tick();
    end
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      rd_hi = 8'($urandom);
      rd_lo = 8'($urandom);
      send(1'($urandom), 4'($urandom), 16'($urandom));
      cmd_valid_i = 1'b0;
      wait_idle();
    end
    bus_intr_i = 1'b1;
    tick();
    bus_intr_i = 1'b0;
    check("intr_sync_delay", intr_pending_o, 0);
    tick();
    tick();
    check("intr_set", intr_pending_o, 1);
    repeat (4) tick();
    bus_intr_i = 1'b1;
    tick();
    bus_intr_i = 1'b0;
    tick();
    intr_clear_i = 1'b1;
    tick();
    intr_clear_i = 1'b0;
    check("intr_edge_and_clear", intr_pending_o, 1);
    repeat (3) tick();
    intr_clear_i = 1'b1;
    tick();
    intr_clear_i = 1'b0;
    check("intr_clear", intr_pending_o, 0);
    send(1'b0, 4'd1, 16'h1357);
    cmd_valid_i = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(bus_bytesel_o && !bus_cs_n_o) && n < 100);
      if (bus_cs_n_o) check("byte1_timeout", 1, 0);
    end
    #2;
    reset_i = 1'b1;
    #1;
    check("abort_cs_n", bus_cs_n_o, 1);
    check("abort_oe", bus_data_oe_o, 0);
    check("abort_rsp", {rsp_valid_o, rsp_rdata_o}, 0);
    check("abort_idle", {cmd_ready_o, busy_o}, 2'b10);
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    rd_hi = 8'h5A;
    rd_lo = 8'hA5;
    send(1'b1, 4'd4, 16'h0000);
    cmd_valid_i = 1'b0;
    wait_idle();
    check("queues_drained", bq.size() + rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
